// File: rtl/uart_frame_sender_pkg.sv
// Shared uart defines: frame-sender and main-controller state codes, frame constants.
// Imported by uart_frame_sender and by the main controller that drives it.
package uart_frame_sender_pkg;

   localparam int unsigned DEF_MAX_BYTES = 16;
   localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;

   localparam logic [2:0] FRAME_IDLE      = 3'd0;
   localparam logic [2:0] FRAME_ISSUE     = 3'd1;
   localparam logic [2:0] FRAME_WAIT_LOW  = 3'd2;
   localparam logic [2:0] FRAME_WAIT_HIGH = 3'd3;
   localparam logic [2:0] FRAME_FINISH    = 3'd4;

   localparam logic [2:0] MAIN_IDLE = 3'd0;
   localparam logic [2:0] MAIN_LOAD = 3'd1;
   localparam logic [2:0] MAIN_SEND = 3'd2;
   localparam logic [2:0] MAIN_WAIT = 3'd3;

   function automatic logic len_valid(input logic [4:0] len, input int unsigned max_bytes);
      return (len != 5'd0) && (32'(len) <= max_bytes);
   endfunction

endpackage

// File: rtl/uart_frame_sender.sv
// Frame sender: SYNC, len, payload bytes, XOR checksum, one byte per uart_transmit handshake.
// Sits between the main controller and uart_transmit.
module uart_frame_sender
   import uart_frame_sender_pkg::*;
#(
   parameter int unsigned MAX_BYTES   = DEF_MAX_BYTES,
   parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [8*MAX_BYTES-1:0] payload,
   input  logic [4:0]             len,
   input  logic                   tx_ready,
   output logic                   tx_send,
   output logic [7:0]             tx_data,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   logic [2:0]             state_q, state_d;
   logic [8*MAX_BYTES-1:0] payload_q, payload_d;
   logic [4:0]             len_q, len_d;
   logic [5:0]             idx_q, idx_d;
   logic [7:0]             csum_q, csum_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   send_q, send_d;
   logic [7:0]             data_q, data_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic                   last_byte;
   logic [7:0]             pay_byte;
   logic [7:0]             cur_byte;

   // Frame index: 0 = sync, 1 = len, 2..len+1 = payload, len+2 = checksum.
   assign last_byte = (idx_q == ({1'b0, len_q} + 6'd2));

   always_comb begin
      pay_byte = 8'h00;
      for (int k = 0; k < MAX_BYTES; k++) begin
         if (idx_q == 6'(k + 2)) begin
            pay_byte = payload_q[8*MAX_BYTES-1-8*k -: 8];
         end
      end
   end

   always_comb begin
      if (idx_q == 6'd0) begin
         cur_byte = SYNC_BYTE;
      end else if (idx_q == 6'd1) begin
         cur_byte = {3'b000, len_q};
      end else if (last_byte) begin
         cur_byte = csum_q;
      end else begin
         cur_byte = pay_byte;
      end
   end

   always_comb begin
      state_d   = state_q;
      payload_d = payload_q;
      len_d     = len_q;
      idx_d     = idx_q;
      csum_d    = csum_q;
      cnt_d     = cnt_q;
      send_d    = 1'b0;
      data_d    = data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         FRAME_IDLE: begin
            if (start) begin
               if (len_valid(len, MAX_BYTES)) begin
                  payload_d = payload;
                  len_d     = len;
                  idx_d     = 6'd0;
                  csum_d    = 8'h00;
                  busy_d    = 1'b1;
                  state_d   = FRAME_ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         FRAME_ISSUE: begin
            if (tx_ready) begin
               data_d  = cur_byte;
               send_d  = 1'b1;
               cnt_d   = '0;
               state_d = FRAME_WAIT_LOW;
               // Sync byte and checksum byte itself are excluded from the checksum.
               if ((idx_q != 6'd0) && !last_byte) begin
                  csum_d = csum_q ^ cur_byte;
               end
            end
         end
         FRAME_WAIT_LOW: begin
            if (!tx_ready) begin
               state_d = FRAME_WAIT_HIGH;
            end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = FRAME_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FRAME_WAIT_HIGH: begin
            if (tx_ready) begin
               idx_d   = idx_q + 6'd1;
               state_d = last_byte ? FRAME_FINISH : FRAME_ISSUE;
            end
         end
         FRAME_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FRAME_IDLE;
         end
         default: begin
            state_d = FRAME_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FRAME_IDLE;
         payload_q <= '0;
         len_q     <= 5'd0;
         idx_q     <= 6'd0;
         csum_q    <= 8'h00;
         cnt_q     <= '0;
         send_q    <= 1'b0;
         data_q    <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         payload_q <= payload_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         csum_q    <= csum_d;
         cnt_q     <= cnt_d;
         send_q    <= send_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign tx_send = send_q;
   assign tx_data = data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Bench for uart_frame_sender: uart_transmit handshake model plus frame-level reference.
// Expected frames are built from payload/len with plain XOR arithmetic.
module tb_uart_frame_sender;

   localparam int MB = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [8*MB-1:0] payload = '0;
   logic [4:0]      len = 5'd0;
   logic            tx_ready = 1'b1;
   logic            tx_send;
   logic [7:0]      tx_data;
   logic            busy;
   logic            done;
   logic            err;

   uart_frame_sender dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .payload  (payload),
      .len      (len),
      .tx_ready (tx_ready),
      .tx_send  (tx_send),
      .tx_data  (tx_data),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int send_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
   int last_send_cyc = 0, err_cyc = 0;
   int lat = 4, low_cnt = 0, hs = 0;
   bit stuck = 1'b0;
   logic [7:0] q[$];
   logic [7:0] pb[MB];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // uart_transmit model: ready drops for lat cycles after each send; also watches handshake order.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         tx_ready = 1'b1;
         low_cnt  = 0;
         hs       = 0;
      end else begin
         if (hs == 1 && !tx_ready) hs = 2;
         else if (hs == 2 && tx_ready) hs = 0;
         if (done) begin
            done_cnt++;
            chk("busy_low_at_done", busy, 0);
            hs = 0;
         end
         if (err) begin
            err_cnt++;
            err_cyc = cyc;
            hs = 0;
         end
         if (done && err) both_cnt++;
         if (tx_send) begin
            chk("handshake_order", hs, 0);
            q.push_back(tx_data);
            send_cnt++;
            last_send_cyc = cyc;
            hs = 1;
            if (!stuck) begin
               tx_ready = 1'b0;
               low_cnt  = lat;
            end
         end else if (low_cnt > 0) begin
            low_cnt--;
            if (low_cnt == 0) tx_ready = 1'b1;
         end
      end
   end

   task automatic load_payload();
      for (int k = 0; k < MB; k++) payload[8*MB-1-8*k -: 8] = pb[k];
   endtask

   task automatic launch(input int n, input int latency);
      load_payload();
      lat = latency;
      q.delete();
      send_cnt = 0;
      done_cnt = 0;
      err_cnt  = 0;
      @(negedge clk);
      start = 1'b1;
      len   = 5'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         if (done_cnt + err_cnt > 0) break;
      end
      chk({tag, "_ended"}, ((done_cnt + err_cnt) > 0) ? 32'd1 : 32'd0, 1);
   endtask

   task automatic check_frame(input string tag, input int n);
      logic [7:0] exp[$];
      logic [7:0] x;
      exp.push_back(8'hA5);
      exp.push_back(8'(n));
      x = 8'(n);
      for (int k = 0; k < n; k++) begin
         exp.push_back(pb[k]);
         x ^= pb[k];
      end
      exp.push_back(x);
      chk({tag, "_count"}, q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), q[i], exp[i]);
      chk({tag, "_done"}, done_cnt, 1);
      chk({tag, "_err"}, err_cnt, 0);
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_tx_send"}, tx_send, 0);
      chk({tag, "_tx_data"}, tx_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   initial begin
      int n;
      logic [7:0] orig[MB];

      #1 check_idle_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed two-byte frame with a slow transmitter.
      pb[0] = 8'h12;
      pb[1] = 8'h34;
      launch(2, 10);
      chk("len2_busy", busy, 1);
      wait_end("len2");
      repeat (2) @(posedge clk);
      check_frame("len2", 2);
      chk("len2_checksum", q[4], 8'h24);

      // Maximum length frame.
      for (int k = 0; k < MB; k++) pb[k] = 8'(k);
      launch(16, $urandom_range(1, 12));
      wait_end("len16");
      repeat (2) @(posedge clk);
      check_frame("len16", 16);
      chk("len16_checksum", q[18], 8'h10);
      chk("len16_sends", send_cnt, 19);

      // Illegal lengths are rejected.
      launch(0, 4);
      repeat (3) @(posedge clk);
      chk("len0_err", err_cnt, 1);
      chk("len0_busy", busy, 0);
      launch(17, 4);
      repeat (3) @(posedge clk);
      chk("len17_err", err_cnt, 1);
      chk("len17_busy", busy, 0);
      chk("reject_no_send", send_cnt, 0);

      // Transmitter never acknowledges.
      stuck = 1'b1;
      for (int k = 0; k < MB; k++) pb[k] = 8'($urandom);
      launch($urandom_range(1, 16), 4);
      wait_end("timeout");
      repeat (2) @(posedge clk);
      chk("timeout_err", err_cnt, 1);
      chk("timeout_no_done", done_cnt, 0);
      chk("timeout_sends", send_cnt, 1);
      chk("timeout_cycles", err_cyc - last_send_cyc, 15);
      chk("timeout_busy", busy, 0);
      stuck = 1'b0;

      // Reset during the third byte, then a fresh one-byte frame.
      for (int k = 0; k < MB; k++) pb[k] = 8'($urandom);
      launch(4, 3);
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         if (send_cnt >= 3) break;
      end
      chk("rst_reached_byte3", send_cnt, 3);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_idle_zero("midrst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("midrst_no_done", done_cnt, 0);
      chk("midrst_no_err", err_cnt, 0);
      pb[0] = 8'hFF;
      launch(1, 5);
      wait_end("after_rst");
      repeat (2) @(posedge clk);
      check_frame("after_rst", 1);
      chk("after_rst_checksum", q[3], 8'hFE);

      // start hammered while busy with changing inputs.
      for (int k = 0; k < MB; k++) pb[k] = 8'($urandom);
      n = $urandom_range(3, 8);
      launch(n, 4);
      orig = pb;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!busy) break;
         start = 1'b1;
         len   = 5'($urandom_range(0, 31));
         for (int k = 0; k < MB; k++) payload[8*MB-1-8*k -: 8] = 8'($urandom);
      end
      start = 1'b0;
      repeat (3) @(posedge clk);
      pb = orig;
      check_frame("busy_start", n);

      // Random frames.
      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < MB; k++) pb[k] = 8'($urandom);
         n = $urandom_range(1, 16);
         launch(n, $urandom_range(1, 12));
         wait_end($sformatf("rand%0d", t));
         repeat (2) @(posedge clk);
         check_frame($sformatf("rand%0d", t), n);
      end

      chk("done_err_exclusive", both_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_frame_sender.md
UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

Interface
REQ-001 Parameters SHALL be: MAX_BYTES, default 16, maximum payload length; SYNC_BYTE, default 8'hA5, first byte of every frame; ACK_TIMEOUT, default 15, maximum cycles to wait for tx_ready to fall after tx_send.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  system clock.
- rst  in  1  async active-high reset.
- start  in  1  request to send one frame; sampled when idle.
- payload  in  8*MAX_BYTES  payload bytes; byte k = payload[8*MAX_BYTES-1-8k -: 8], sent first-to-last.
- len  in  5  payload byte count, 1..MAX_BYTES.
- tx_ready  in  1  ready from uart_transmit.
- tx_send  out  1  one-cycle send strobe to uart_transmit.
- tx_data  out  8  byte presented to uart_transmit.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  one-cycle pulse on a rejected start or an ack timeout.

Function
REQ-004 The frame SHALL be: SYNC_BYTE, then len zero-extended to 8 bits, then payload bytes 0..len-1, then a checksum, giving len+3 bytes.
REQ-005 The checksum SHALL be the XOR of the len byte and all sent payload bytes.
REQ-006 States SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, FINISH.
REQ-007 In IDLE, when start=1 and 1<=len<=MAX_BYTES, the block SHALL latch payload and len, clear the byte index and checksum, set busy, and go to ISSUE.
REQ-008 In IDLE, when start=1 and len=0 or len>MAX_BYTES, the block SHALL pulse err for one cycle and remain in IDLE with busy=0.
REQ-009 In ISSUE, when tx_ready=1, the block SHALL drive tx_data with the current byte, pulse tx_send for exactly one cycle, and go to WAIT_LOW. While tx_ready=0 it SHALL stay in ISSUE.
REQ-010 tx_data SHALL hold its value from the tx_send cycle until the block next enters ISSUE.
REQ-011 In WAIT_LOW, tx_ready=0 SHALL move the block to WAIT_HIGH.
REQ-012 In WAIT_LOW, if tx_ready stays 1 for ACK_TIMEOUT cycles, the block SHALL pulse err, clear busy, and return to IDLE without pulsing done.
REQ-013 In WAIT_HIGH, tx_ready=1 SHALL advance the index. The block SHALL go to FINISH if the checksum byte was just sent, otherwise to ISSUE.
REQ-014 The block SHALL never assert tx_send for a new byte before tx_ready has been seen low and then high again for the previous byte.
REQ-015 FINISH SHALL pulse done for one cycle, clear busy, and enter IDLE on the next cycle.
REQ-016 start while busy=1 SHALL be ignored, with no err and no change to the latched data.
REQ-017 Changes to payload or len while busy=1 SHALL NOT affect the frame in progress.
REQ-018 The checksum SHALL update in the cycle each payload byte is issued, so the checksum byte equals the XOR of all earlier bytes except SYNC_BYTE.
REQ-019 The index SHALL be at least 5 bits wide and SHALL NOT wrap for any legal len.
REQ-020 done and err SHALL never be asserted in the same cycle.

Reset
REQ-021 Asserting rst SHALL immediately force state=IDLE, tx_send=0, tx_data=8'h00, busy=0, done=0, err=0, index=0, and checksum=0.
REQ-022 Reset mid-frame SHALL abandon the frame with no done or err pulse. The first start after rst falls SHALL send a complete new frame.

Structure
REQ-023 State codes (FRAME_IDLE..FRAME_FINISH), SYNC_BYTE, and the default MAX_BYTES SHALL live in the shared uart defines header alongside the MAIN_* state codes.
REQ-024 No sub-module is required. Byte selection SHALL be an internal combinational mux on the index.
REQ-025 The block SHALL instantiate directly between the main controller and uart_transmit, replacing the single-byte send FSM.

Verification
REQ-026 len=2, payload bytes 8'h12 and 8'h34, uart_transmit model ready low for 10 cycles after each send -> bytes A5,02,12,34,24 in order, done pulses once, busy falls with done.
REQ-027 len=16, payload bytes 00..0F -> 19 bytes sent, checksum 8'h10, exactly 19 tx_send pulses.
REQ-028 start with len=0, then with len=17 -> err pulses on each, tx_send is never asserted, busy stays 0.
REQ-029 tx_ready held at 1 after the first tx_send -> err after 15 cycles, busy=0, no done.
REQ-030 rst asserted during the 3rd byte, then start with len=1 and payload 8'hFF -> all outputs zero immediately on rst, then frame A5,01,FF,FE is sent.
REQ-031 start re-asserted every cycle while busy, with payload changed -> only the originally latched frame is sent, no err.
